// File: rtl/load_store_unit_pkg.sv
// Shared load/store unit types: FSM states, RV32I size codes, lane-mask helper.
// MISALIGN_SPLIT_EN adds the second-access states ISSUE2/WAIT2.
package lsu_pkg;

`ifdef MISALIGN_SPLIT_EN
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ISSUE2, S_WAIT2} lsu_state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} lsu_state_t;
`endif

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] wdata;
   } lsu_req_t;

   // Byte lanes touched across two consecutive words: bits [3:0] first word, [7:4] second.
   function automatic logic [7:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
      logic [7:0] base;
      case (funct3[1:0])
         2'b00:   base = 8'h01;
         2'b01:   base = 8'h03;
         default: base = 8'h0F;
      endcase
      return base << off;
   endfunction

   function automatic logic f3_illegal(input logic [2:0] funct3, input logic we);
      return (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && we);
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bus and memory-side command/return bus of the load/store unit.
interface lsu_req_if #(parameter int ADDR_W = 32);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                   input  req_ready, rsp_valid, rsp_rdata, rsp_err);
   modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 32);
   logic              mem_valid;
   logic              mem_ready;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (output mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
                   input  mem_ready, mem_rvalid, mem_rdata);
   modport slave  (input  mem_valid, mem_we, mem_be, mem_addr, mem_wdata,
                   output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/load_store_unit_align.sv
// Load data alignment: pick the addressed bytes out of two words and sign/zero extend.
module load_align
   import lsu_pkg::*;
(
   input  logic [63:0] data,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata
);
   logic [31:0] word;

   assign word = data[{off, 3'b000} +: 32];

   always_comb begin
      rdata = '0;
      case (funct3)
         F3_B:    rdata = {{24{word[7]}}, word[7:0]};
         F3_H:    rdata = {{16{word[15]}}, word[15:0]};
         F3_W:    rdata = word;
         F3_BU:   rdata = {24'b0, word[7:0]};
         F3_HU:   rdata = {16'b0, word[15:0]};
         default: rdata = '0;
      endcase
   end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, byte-lane placement, load extension.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two memory accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic       clk,
   input  logic       resetn,
   lsu_req_if.slave   core,
   lsu_mem_if.master  mem
);
   lsu_state_t        state, state_nx;
   lsu_req_t          rq;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] base_addr;
   logic [31:0]       rsp_rdata_q;
   logic              rsp_err_q;
   logic              bad_req;
   logic              issuing;
   logic              in_wait;
   logic [ADDR_W-1:0] issue_addr;
   logic [3:0]        issue_be;
   logic [31:0]       issue_wdata;
   logic [63:0]       ld_word;
   logic [31:0]       ld_data;

   assign base_addr = {r_addr[ADDR_W-1:2], 2'b00};

   always_comb begin
      bad_req = f3_illegal(core.req_funct3, core.req_we);
`ifndef MISALIGN_SPLIT_EN
      // without splitting, any halfword/word not naturally aligned is rejected
      if (core.req_funct3[1:0] == 2'b01 && core.req_addr[0])          bad_req = 1'b1;
      if (core.req_funct3[1:0] == 2'b10 && core.req_addr[1:0] != 2'b00) bad_req = 1'b1;
`endif
   end

`ifdef MISALIGN_SPLIT_EN
   logic [7:0]  mask;
   logic [63:0] wide;
   logic [31:0] lo_q;
   logic        split;
   logic        second;

   assign mask        = lane_mask(rq.funct3, r_addr[1:0]);
   assign wide        = {32'b0, rq.wdata} << {r_addr[1:0], 3'b000};
   assign split       = |mask[7:4];
   assign second      = (state == S_ISSUE2);
   assign issuing     = (state == S_ISSUE) || (state == S_ISSUE2);
   assign in_wait     = (state == S_WAIT)  || (state == S_WAIT2);
   assign issue_addr  = second ? base_addr + ADDR_W'(4) : base_addr;
   assign issue_be    = second ? mask[7:4]   : mask[3:0];
   assign issue_wdata = second ? wide[63:32] : wide[31:0];
   assign ld_word     = (state == S_WAIT2) ? {mem.mem_rdata, lo_q} : {32'b0, mem.mem_rdata};

   always_ff @(posedge clk) begin
      if (!resetn)                                   lo_q <= '0;
      else if (state == S_WAIT && mem.mem_rvalid)    lo_q <= mem.mem_rdata;
   end
`else
   assign issuing     = (state == S_ISSUE);
   assign in_wait     = (state == S_WAIT);
   assign issue_addr  = base_addr;
   assign issue_be    = 4'(lane_mask(rq.funct3, r_addr[1:0]));
   assign issue_wdata = rq.wdata << {r_addr[1:0], 3'b000};
   assign ld_word     = {32'b0, mem.mem_rdata};
`endif

   load_align u_align (
      .data   (ld_word),
      .off    (r_addr[1:0]),
      .funct3 (rq.funct3),
      .rdata  (ld_data)
   );

   always_ff @(posedge clk) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (core.req_valid) state_nx = bad_req ? S_RESP : S_ISSUE;
         S_ISSUE: if (mem.mem_ready) begin
                     if (!rq.we) state_nx = S_WAIT;
`ifdef MISALIGN_SPLIT_EN
                     else        state_nx = split ? S_ISSUE2 : S_RESP;
`else
                     else        state_nx = S_RESP;
`endif
                  end
`ifdef MISALIGN_SPLIT_EN
         S_WAIT:   if (mem.mem_rvalid) state_nx = split ? S_ISSUE2 : S_RESP;
         S_ISSUE2: if (mem.mem_ready)  state_nx = rq.we ? S_RESP : S_WAIT2;
         S_WAIT2:  if (mem.mem_rvalid) state_nx = S_RESP;
`else
         S_WAIT:   if (mem.mem_rvalid) state_nx = S_RESP;
`endif
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Response registers change only on entry to RESP so they hold between responses.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rq          <= '0;
         r_addr      <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (state == S_IDLE && core.req_valid) begin
            rq     <= '{we: core.req_we, funct3: core.req_funct3, wdata: core.req_wdata};
            r_addr <= core.req_addr;
         end
         if (state_nx == S_RESP && state != S_RESP) begin
            rsp_err_q   <= (state == S_IDLE);
            rsp_rdata_q <= in_wait ? ld_data : 32'h0;
         end
      end
   end

   always_comb begin
      core.req_ready = (state == S_IDLE);
      core.rsp_valid = (state == S_RESP);
      mem.mem_valid  = issuing;
      mem.mem_we     = issuing & rq.we;
      mem.mem_be     = issuing ? issue_be : 4'h0;
      mem.mem_addr   = issuing ? issue_addr : '0;
      mem.mem_wdata  = (issuing && rq.we) ? issue_wdata : 32'h0;
   end

   assign core.rsp_rdata = rsp_rdata_q;
   assign core.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small 4-word memory responder.
module tb_load_store_unit;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   lsu_req_if #(.ADDR_W(32)) core();
   lsu_mem_if #(.ADDR_W(32)) mem();

   load_store_unit #(.ADDR_W(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .core   (core.slave),
      .mem    (mem.master)
   );

   int n_chk = 0;
   int n_bad = 0;

   // responder-owned state
   logic [31:0] words [4] = '{32'hF00F81AA, 32'h2A82CC33, 32'h0, 32'h0};
   int          hs_n = 0, vcyc = 0, stall_used = 0;
   bit          pend = 0;
   logic [1:0]  pend_idx = '0;
   logic [31:0] log_addr [16];
   logic [3:0]  log_be   [16];
   logic [31:0] log_wd   [16];
   logic        log_we   [16];
   // test-owned knobs
   int          stall_tgt = 0;
   bit          manual = 0;
   logic        man_rv = 1'b0;
   logic [31:0] man_rd = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Read data returns the cycle after a load handshake; stores update the word array.
   always @(negedge clk) begin
      mem.mem_rvalid = 1'b0;
      mem.mem_rdata  = '0;
      if (manual) begin
         mem.mem_rvalid = man_rv;
         mem.mem_rdata  = man_rd;
         pend = 0;
      end else if (pend) begin
         mem.mem_rvalid = 1'b1;
         mem.mem_rdata  = words[pend_idx];
         pend = 0;
      end
      mem.mem_ready = 1'b1;
      if (mem.mem_valid === 1'b1) begin
         vcyc++;
         if (stall_used < stall_tgt) begin
            mem.mem_ready = 1'b0;
            stall_used++;
         end else begin
            log_addr[hs_n & 15] = mem.mem_addr;
            log_be[hs_n & 15]   = mem.mem_be;
            log_wd[hs_n & 15]   = mem.mem_wdata;
            log_we[hs_n & 15]   = mem.mem_we;
            hs_n++;
            if (mem.mem_we) begin
               for (int b = 0; b < 4; b++)
                  if (mem.mem_be[b]) words[mem.mem_addr[3:2]][8*b +: 8] = mem.mem_wdata[8*b +: 8];
            end else begin
               pend = 1;
               pend_idx = mem.mem_addr[3:2];
            end
         end
      end
   end

   task automatic issue_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd);
      @(negedge clk);
      core.req_valid = 1'b1; core.req_we = we; core.req_funct3 = f3;
      core.req_addr = addr;  core.req_wdata = wd;
      @(posedge clk);
   endtask

   task automatic wait_rsp(output int n, output logic [31:0] rd, output logic err);
      n = 0; rd = 'x; err = 1'bx;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i == 1) core.req_valid = 1'b0;
         if (core.rsp_valid === 1'b1) begin
            n = i; rd = core.rsp_rdata; err = core.rsp_err;
            break;
         end
      end
      if (n == 0) chk("rsp_timeout", 32'd0, 32'd1);
   endtask

   // Full transaction; base is the log index of its first memory command.
   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, output int n, output logic [31:0] rd,
                      output logic err, output int hs, output int vc, output int base);
      int hs0, vc0;
      hs0 = hs_n; vc0 = vcyc; base = hs0 & 15;
      issue_req(we, f3, addr, wd);
      wait_rsp(n, rd, err);
      @(negedge clk);
      chk("rsp_one_cycle", {31'b0, core.rsp_valid}, 32'd0);
      hs = hs_n - hs0; vc = vcyc - vc0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, hs, vc, b;
      logic [31:0] rd;
      logic err;
      core.req_valid = 1'b0; core.req_we = 1'b0; core.req_funct3 = 3'b0;
      core.req_addr = '0;    core.req_wdata = '0;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'b0, core.req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, core.rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", core.rsp_rdata, 32'd0);
      chk("rst_rsp_err",   {31'b0, core.rsp_err}, 32'd0);
      chk("rst_mem_valid", {31'b0, mem.mem_valid}, 32'd0);
      chk("rst_mem_we",    {31'b0, mem.mem_we}, 32'd0);
      chk("rst_mem_be",    {28'b0, mem.mem_be}, 32'd0);
      chk("rst_mem_addr",  mem.mem_addr, 32'd0);
      chk("rst_mem_wdata", mem.mem_wdata, 32'd0);
      resetn = 1'b1;

      // LB 0x6 on 0x2A82CC33
      txn(1'b0, 3'b000, 32'h6, 32'h0, n, rd, err, hs, vc, b);
      chk("lb_lat", n, 3);  chk("lb_data", rd, 32'hFFFFFF82); chk("lb_err", {31'b0, err}, 0);
      chk("lb_cmds", hs, 1); chk("lb_addr", log_addr[b], 32'h4); chk("lb_be", {28'b0, log_be[b]}, 4'h4);
      chk("lb_we", {31'b0, log_we[b]}, 0);
      chk("rsp_hold", core.rsp_rdata, 32'hFFFFFF82);
      txn(1'b0, 3'b100, 32'h6, 32'h0, n, rd, err, hs, vc, b);
      chk("lbu_data", rd, 32'h00000082);
      txn(1'b0, 3'b001, 32'h2, 32'h0, n, rd, err, hs, vc, b);
      chk("lh_data", rd, 32'hFFFFF00F); chk("lh_be", {28'b0, log_be[b]}, 4'hC); chk("lh_addr", log_addr[b], 0);
      txn(1'b0, 3'b101, 32'h2, 32'h0, n, rd, err, hs, vc, b);
      chk("lhu_data", rd, 32'h0000F00F);
      txn(1'b0, 3'b010, 32'h4, 32'h0, n, rd, err, hs, vc, b);
      chk("lw_data", rd, 32'h2A82CC33); chk("lw_be", {28'b0, log_be[b]}, 4'hF);

      // word-crossing word / half loads
      txn(1'b0, 3'b010, 32'h1, 32'h0, n, rd, err, hs, vc, b);
`ifdef MISALIGN_SPLIT_EN
      chk("lw1_lat", n, 5); chk("lw1_cmds", hs, 2); chk("lw1_data", rd, 32'h33F00F81);
      chk("lw1_addr0", log_addr[b], 32'h0); chk("lw1_be0", {28'b0, log_be[b]}, 4'hE);
      chk("lw1_addr1", log_addr[(b+1)&15], 32'h4); chk("lw1_be1", {28'b0, log_be[(b+1)&15]}, 4'h1);
`else
      chk("lw1_err", {31'b0, err}, 1); chk("lw1_data", rd, 0); chk("lw1_nomem", vc, 0); chk("lw1_lat", n, 1);
`endif
      txn(1'b0, 3'b001, 32'h3, 32'h0, n, rd, err, hs, vc, b);
`ifdef MISALIGN_SPLIT_EN
      chk("lh3_data", rd, 32'h000033F0); chk("lh3_cmds", hs, 2);
`else
      chk("lh3_err", {31'b0, err}, 1); chk("lh3_nomem", vc, 0);
`endif

      // SH 0x1234 @0x2, then read back the word
      txn(1'b1, 3'b001, 32'h2, 32'h00001234, n, rd, err, hs, vc, b);
      chk("sh_lat", n, 2); chk("sh_be", {28'b0, log_be[b]}, 4'hC); chk("sh_wdata", log_wd[b], 32'h12340000);
      chk("sh_we", {31'b0, log_we[b]}, 1); chk("sh_rdata", rd, 0); chk("sh_err", {31'b0, err}, 0);
      txn(1'b0, 3'b010, 32'h0, 32'h0, n, rd, err, hs, vc, b);
      chk("sh_readback", rd, 32'h123481AA);

      // SB drops upper wdata bits
      txn(1'b1, 3'b000, 32'hF, 32'h123456AB, n, rd, err, hs, vc, b);
      chk("sb_be", {28'b0, log_be[b]}, 4'h8); chk("sb_wdata", log_wd[b], 32'hAB000000);
      chk("sb_addr", log_addr[b], 32'hC);
      txn(1'b0, 3'b100, 32'hF, 32'h0, n, rd, err, hs, vc, b);
      chk("sb_readback", rd, 32'h000000AB);

      // illegal size codes
      txn(1'b0, 3'b011, 32'h4, 32'h0, n, rd, err, hs, vc, b);
      chk("f3_011_err", {31'b0, err}, 1); chk("f3_011_lat", n, 1); chk("f3_011_nomem", vc, 0);
      chk("f3_011_data", rd, 0);
      txn(1'b1, 3'b101, 32'h4, 32'h0, n, rd, err, hs, vc, b);
      chk("shu_err", {31'b0, err}, 1); chk("shu_nomem", vc, 0);

      // memory back-pressure for 5 cycles
      stall_tgt = stall_used + 5;
      issue_req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         core.req_valid = 1'b0;
         chk("stall_valid", {31'b0, mem.mem_valid}, 1);
         chk("stall_addr",  mem.mem_addr, 32'h8);
         chk("stall_be",    {28'b0, mem.mem_be}, 4'hF);
         chk("stall_wdata", mem.mem_wdata, 32'hDEADBEEF);
         chk("stall_ready", {31'b0, core.req_ready}, 0);
      end
      wait_rsp(n, rd, err);
      chk("stall_lat", n, 2);
      txn(1'b0, 3'b010, 32'h8, 32'h0, n, rd, err, hs, vc, b);
      chk("stall_readback", rd, 32'hDEADBEEF);

      // reset while waiting for load data, then a late rvalid
      manual = 1;
      issue_req(1'b0, 3'b010, 32'h4, 32'h0);
      @(negedge clk);
      core.req_valid = 1'b0;
      @(negedge clk);
      chk("rw_in_wait", {31'b0, core.req_ready}, 0);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      man_rv = 1'b1; man_rd = 32'h5555AAAA;
      chk("rw_rdata", core.rsp_rdata, 0);
      chk("rw_err", {31'b0, core.rsp_err}, 0);
      chk("rw_mem_valid", {31'b0, mem.mem_valid}, 0);
      for (int k = 0; k < 4; k++) begin
         chk("rw_no_rsp", {31'b0, core.rsp_valid}, 0);
         chk("rw_ready", {31'b0, core.req_ready}, 1);
         @(negedge clk);
         if (k == 1) man_rv = 1'b0;
      end
      manual = 0;
      txn(1'b0, 3'b000, 32'h6, 32'h0, n, rd, err, hs, vc, b);
      chk("post_rst_lb", rd, 32'hFFFFFF82); chk("post_rst_lat", n, 3);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of the core and memory address ports.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  core access request.
REQ-005 req_ready  output  1  unit idle and accepting requests.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  ADDR_W  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 rsp_err  output  1  access rejected, valid with rsp_valid.
REQ-013 mem_valid / mem_ready  output / input  1 / 1  memory command handshake.
REQ-014 mem_we  output  1  memory write strobe.
REQ-015 mem_be  output  4  byte enables, bit i = byte lane i.
REQ-016 mem_addr  output  ADDR_W  word-aligned address, bits [1:0] always 00.
REQ-017 mem_wdata  output  32  lane-positioned store data.
REQ-018 mem_rvalid / mem_rdata  input / input  1 / 32  load data return, never earlier than the cycle after the matching command handshake.

Function
REQ-019 States: IDLE, ISSUE, WAIT, RESP, plus ISSUE2, WAIT2 when split is compiled in; req_ready=1 only in IDLE.
REQ-020 IDLE and req_valid: latch the request and go to ISSUE; an illegal funct3 (011, 110, 111; or 1xx with req_we=1) goes directly to RESP with rsp_err=1 and no memory access.
REQ-021 ISSUE: hold mem_valid=1 and stable mem_* outputs until mem_ready; then stores go to RESP (or ISSUE2), loads go to WAIT (or WAIT2 after the second part).
REQ-022 WAIT: capture mem_rdata on mem_rvalid, then go to RESP.
REQ-023 RESP: rsp_valid=1 for exactly one cycle, then IDLE; rsp_rdata and rsp_err are registered and stay stable until the next RESP.
REQ-024 8-bit lane mask = (B:0x1, H:0x3, W:0xF) << addr[1:0]; mem_be = mask[3:0] for the first part and mask[7:4] for the second part.
REQ-025 Store data: 64-bit {32'b0, req_wdata} << 8*addr[1:0]; the low word goes to the first part and the high word to the second part.
REQ-026 Load data: 64-bit {second, first} >> 8*addr[1:0], then B/H sign-extend and BU/HU zero-extend into 32 bits.
REQ-027 Minimum latency with mem_ready=1 and mem_rvalid one cycle later: store accepted in cycle 0 gives rsp_valid in cycle 2; load gives rsp_valid in cycle 3.
REQ-028 mem_rvalid outside WAIT/WAIT2 is ignored.

Reset
REQ-029 resetn low on a clock edge: state goes to IDLE, and every output except req_ready is 0 (req_ready=1), including mid-transaction.
REQ-030 Any in-flight memory transaction is abandoned and its late mem_rvalid is ignored.

Configuration
REQ-031 Macro MISALIGN_SPLIT_EN defined: an access with a nonzero mask[7:4] performs two sequential accesses, at addr&~3 then (addr&~3)+4, wrapping modulo 2^ADDR_W; a misaligned access with mask[7:4]=0 is a single access.
REQ-032 MISALIGN_SPLIT_EN undefined: H with addr[0]=1, or W with addr[1:0]!=0, returns rsp_err=1 with no memory access; ISSUE2 and WAIT2 are absent.

Structure
REQ-033 Package lsu_pkg holds the state enum, the funct3 localparams and the lane-mask function.
REQ-034 Sub-module load_align (combinational shift and extend per REQ-026) is instantiated once.

Verification
REQ-035 LB at 0x6 with word 0x2A82CC33 at 0x4 -> mem_addr=0x4, mem_be=0x4, rsp_rdata=0xFFFFFF82.
REQ-036 SH of 0x1234 at 0x2 -> mem_be=0xC, mem_wdata=0x12340000, rsp_valid 2 cycles after acceptance.
REQ-037 LW at 0x1 with MISALIGN_SPLIT_EN, words 0xF00F81AA@0, 0x2A82CC33@4 -> two commands at 0x0 then 0x4, rsp_rdata=0x33F00F81.
REQ-038 LW at 0x1 without MISALIGN_SPLIT_EN -> no mem_valid, rsp_err=1, rsp_rdata=0.
REQ-039 mem_ready held low 5 cycles -> mem_* outputs stable, req_ready=0 throughout.
REQ-040 resetn low while in WAIT, then mem_rvalid -> IDLE, no rsp_valid, req_ready=1.
